// File: rtl/io_switch_matrix_cfg_if.sv
// Bundle for the IO switch matrix: routing wires, serial config handshake and pad outputs.
// The block takes the slave modport; the driver of config and wires takes master.
interface io_switch_matrix_cfg_if #(
    parameter int NUM_CH    = 2,
    parameter int NUM_WIRES = 16
);
    localparam int SEL_W    = $clog2(NUM_WIRES);
    localparam int CFG_BITS = NUM_CH * (SEL_W + 2);

    logic [NUM_WIRES-1:0] wires_in;
    logic                 cfg_in_valid;
    logic                 cfg_in_ready;
    logic                 cfg_in_data;
    logic                 cfg_abort;
    logic                 cfg_out;
    logic                 cfg_done;
    logic [CFG_BITS-1:0]  cfg_active;
    logic [NUM_CH-1:0]    ch_i;
    logic [NUM_CH-1:0]    ch_t;

    modport master (
        output wires_in, cfg_in_valid, cfg_in_data, cfg_abort,
        input  cfg_in_ready, cfg_out, cfg_done, cfg_active, ch_i, ch_t
    );

    modport slave (
        input  wires_in, cfg_in_valid, cfg_in_data, cfg_abort,
        output cfg_in_ready, cfg_out, cfg_done, cfg_active, ch_i, ch_t
    );
endinterface

// File: rtl/io_switch_matrix_cfg.sv
// IO-tile switch matrix with serially loaded shadow/active config and atomic commit.
// Optional macro IO_SWMX_OUTREG_EN registers ch_i/ch_t for one cycle of extra latency.

// One channel: I-mux over the wire bundle, T-mux over VCC/GND/two fixed wires.
module io_swmx_lane #(
    parameter int NUM_WIRES = 16,
    parameter int SEL_W     = 4,
    parameter int T_SRC_A   = 0,
    parameter int T_SRC_B   = 15
) (
    input  logic [NUM_WIRES-1:0] wires_i,
    input  logic [SEL_W-1:0]     isel_i,
    input  logic [1:0]           tsel_i,
    output logic                 i_o,
    output logic                 t_o
);
    // Padding to a power of two makes out-of-range selects read a zero.
    logic [2**SEL_W-1:0] wpad;

    always_comb begin
        wpad                 = '0;
        wpad[NUM_WIRES-1:0]  = wires_i;
    end

    assign i_o = wpad[isel_i];

    always_comb begin
        t_o = 1'b1;
        case (tsel_i)
            2'd0:    t_o = 1'b1;
            2'd1:    t_o = 1'b0;
            2'd2:    t_o = wires_i[T_SRC_A];
            default: t_o = wires_i[T_SRC_B];
        endcase
    end
endmodule

module io_switch_matrix_cfg #(
    parameter int NUM_CH    = 2,
    parameter int NUM_WIRES = 16,
    parameter int T_SRC_A   = 0,
    parameter int T_SRC_B   = NUM_WIRES - 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    io_switch_matrix_cfg_if.slave   bus
);
    localparam int SEL_W    = $clog2(NUM_WIRES);
    localparam int FLD_W    = SEL_W + 2;
    localparam int CFG_BITS = NUM_CH * FLD_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q;
    logic                ready_q;
    logic                done_q;
    logic                accept;

    // Abort takes priority: a bit offered alongside it is dropped.
    assign accept   = bus.cfg_in_valid && ready_q && !bus.cfg_abort;
    assign shadow_d = {shadow_q[CFG_BITS-2:0], bus.cfg_in_data};
    assign cnt_d    = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, SHIFT: begin
                    if (bus.cfg_abort) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (accept) begin
                        shadow_q <= shadow_d;
                        cnt_q    <= cnt_d;
                        if (cnt_d == CNT_W'(CFG_BITS)) begin
                            state_q <= COMMIT;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                COMMIT: begin
                    active_q <= shadow_q;
                    cnt_q    <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cfg_in_ready = ready_q;
    assign bus.cfg_done     = done_q;
    assign bus.cfg_out      = shadow_q[CFG_BITS-1];
    assign bus.cfg_active   = active_q;

    logic [NUM_CH-1:0] ch_i_c, ch_t_c;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        io_swmx_lane #(
            .NUM_WIRES (NUM_WIRES),
            .SEL_W     (SEL_W),
            .T_SRC_A   (T_SRC_A),
            .T_SRC_B   (T_SRC_B)
        ) u_lane (
            .wires_i (bus.wires_in),
            .isel_i  (active_q[c*FLD_W +: SEL_W]),
            .tsel_i  (active_q[c*FLD_W+SEL_W +: 2]),
            .i_o     (ch_i_c[c]),
            .t_o     (ch_t_c[c])
        );
    end

`ifdef IO_SWMX_OUTREG_EN
    logic [NUM_CH-1:0] ch_i_q, ch_t_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ch_i_q <= '0;
            ch_t_q <= '1;
        end else begin
            ch_i_q <= ch_i_c;
            ch_t_q <= ch_t_c;
        end
    end

    assign bus.ch_i = ch_i_q;
    assign bus.ch_t = ch_t_q;
`else
    assign bus.ch_i = ch_i_c;
    assign bus.ch_t = ch_t_c;
`endif
endmodule

// File: tb/tb_io_switch_matrix_cfg.sv
// Scoreboard bench for io_switch_matrix_cfg: a 16-wire and a 12-wire instance share one stimulus.
module tb_io_switch_matrix_cfg;
    localparam int NCH = 2, NW = 16, NW12 = 12, CB = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    io_switch_matrix_cfg_if #(.NUM_CH(NCH), .NUM_WIRES(NW))   bif ();
    io_switch_matrix_cfg_if #(.NUM_CH(NCH), .NUM_WIRES(NW12)) bif12 ();

    io_switch_matrix_cfg #(.NUM_CH(NCH), .NUM_WIRES(NW))   dut   (.clk_i(clk), .rst_i(rst), .bus(bif));
    io_switch_matrix_cfg #(.NUM_CH(NCH), .NUM_WIRES(NW12)) dut12 (.clk_i(clk), .rst_i(rst), .bus(bif12));

    assign bif12.wires_in     = bif.wires_in[NW12-1:0];
    assign bif12.cfg_in_valid = bif.cfg_in_valid;
    assign bif12.cfg_in_data  = bif.cfg_in_data;
    assign bif12.cfg_abort    = bif.cfg_abort;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state
    logic [CB-1:0] m_shadow = '0, m_active = '0;
    int            m_cnt = 0;
    bit            m_commit_pend = 0, m_act_pend = 0, mon_en = 0;
    logic [CB-1:0] exp_q[$];
    logic          chain_q[$];
    logic [1:0]    prev_i = 2'b00, prev_t = 2'b11, prev12_i = 2'b00, prev12_t = 2'b11;

    function automatic logic [1:0] f_chi(input logic [CB-1:0] act, input logic [NW-1:0] w, input int nw);
        logic [1:0] r;
        int sel;
        for (int c = 0; c < NCH; c++) begin
            sel  = int'(act[c*6 +: 4]);
            r[c] = (sel < nw) ? w[sel] : 1'b0;
        end
        return r;
    endfunction

    function automatic logic [1:0] f_cht(input logic [CB-1:0] act, input logic [NW-1:0] w, input int nw);
        logic [1:0] r;
        for (int c = 0; c < NCH; c++) begin
            case (act[c*6+4 +: 2])
                2'd0:    r[c] = 1'b1;
                2'd1:    r[c] = 1'b0;
                2'd2:    r[c] = w[0];
                default: r[c] = w[nw-1];
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_shadow = '0; m_active = '0; m_cnt = 0;
        m_commit_pend = 0; m_act_pend = 0;
        exp_q.delete(); chain_q.delete();
        prev_i = 2'b00; prev_t = 2'b11; prev12_i = 2'b00; prev12_t = 2'b11;
    endtask

    // Monitor: sample 1 time unit after the falling edge so inputs driven at that edge have settled.
    always @(negedge clk) begin
        logic [1:0] ci, ct, ci12, ct12;
        logic [NW-1:0] w12;
        #1;
        if (mon_en && !rst) begin
            chk("cfg_out", bif.cfg_out, m_shadow[CB-1]);
            chk("cfg_done", bif.cfg_done, m_commit_pend);
            chk("cfg_in_ready", bif.cfg_in_ready, !m_commit_pend);
            if (m_act_pend) begin
                if (exp_q.size() == 0) chk("exp_q_underflow", 32'd0, 32'd1);
                else m_active = exp_q.pop_front();
                m_act_pend = 0;
            end
            if (m_commit_pend) begin
                m_commit_pend = 0;
                m_act_pend    = 1;
            end
            chk("cfg_active", bif.cfg_active, m_active);
            chk("cfg_active12", bif12.cfg_active, m_active);
            w12  = {4'b0, bif.wires_in[NW12-1:0]};
            ci   = f_chi(m_active, bif.wires_in, NW);
            ct   = f_cht(m_active, bif.wires_in, NW);
            ci12 = f_chi(m_active, w12, NW12);
            ct12 = f_cht(m_active, w12, NW12);
`ifdef IO_SWMX_OUTREG_EN
            chk("ch_i", bif.ch_i, prev_i);
            chk("ch_t", bif.ch_t, prev_t);
            chk("ch_i12", bif12.ch_i, prev12_i);
            chk("ch_t12", bif12.ch_t, prev12_t);
`else
            chk("ch_i", bif.ch_i, ci);
            chk("ch_t", bif.ch_t, ct);
            chk("ch_i12", bif12.ch_i, ci12);
            chk("ch_t12", bif12.ch_t, ct12);
`endif
            prev_i = ci; prev_t = ct; prev12_i = ci12; prev12_t = ct12;
        end
    end

    // Offer one bit (after 'gap' idle cycles) until accepted; starts and ends at a falling edge.
    task automatic send_bit(input logic b, input int gap, output int ncyc);
        logic acc;
        acc = 1'b0;
        bif.cfg_in_valid = 1'b0;
        repeat (gap) begin
            bif.wires_in = NW'($urandom);
            @(negedge clk);
        end
        bif.wires_in     = NW'($urandom);
        bif.cfg_in_valid = 1'b1;
        bif.cfg_in_data  = b;
        ncyc = 0;
        forever begin
            acc = bif.cfg_in_ready;
            @(posedge clk);
            ncyc++;
            if (acc) break;
            if (ncyc > 20) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
        end
        if (acc) begin
            m_shadow = {m_shadow[CB-2:0], b};
            m_cnt++;
            chain_q.push_back(b);
            if (m_cnt == CB) begin
                exp_q.push_back(m_shadow);
                m_cnt = 0;
                m_commit_pend = 1;
            end
        end
        @(negedge clk);
        bif.cfg_in_valid = 1'b0;
    endtask

    task automatic load(input logic [CB-1:0] cfg, input int maxgap);
        int n;
        for (int i = CB - 1; i >= 0; i--) send_bit(cfg[i], $urandom_range(0, maxgap), n);
    endtask

    initial begin
        int n;
        logic [CB-1:0] cfg;
        bif.cfg_in_valid = 1'b0;
        bif.cfg_in_data  = 1'b0;
        bif.cfg_abort    = 1'b0;
        bif.wires_in     = 16'hFFFF;

        // Reset state with all wires high
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ch_t", bif.ch_t, 2'b11);
`ifdef IO_SWMX_OUTREG_EN
        chk("rst_ch_i", bif.ch_i, 2'b00);
`else
        chk("rst_ch_i", bif.ch_i, 2'b11);
`endif
        chk("rst_active", bif.cfg_active, 0);
        chk("rst_ready", bif.cfg_in_ready, 1);
        chk("rst_cfg_out", bif.cfg_out, 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;
        repeat (3) @(negedge clk);

        // Full load, back to back: ch1 T=2 I=5, ch0 T=1 I=3
        cfg = 12'b10_0101_01_0011;
        for (int i = CB - 1; i >= 0; i--) begin
            bif.cfg_in_valid = 1'b1;
            send_bit(cfg[i], 0, n);
        end
        chk("done_after_12", bif.cfg_done, 1);
        chk("ready_after_12", bif.cfg_in_ready, 0);
        @(negedge clk);
        bif.wires_in = 16'h0028;
        @(negedge clk);
        #1;
        chk("route_ch_i", bif.ch_i, 2'b11);
        chk("route_ch_t", bif.ch_t, 2'b00);

        // Random gaps, then a bit offered during COMMIT waits one cycle
        @(negedge clk);
        load(12'b11_1010_00_0110, 3);
        send_bit(1'b1, 0, n);
        chk("commit_hold_cycles", n, 2);
        cfg = 12'b1_0111_11_1001;
        for (int i = CB - 2; i >= 0; i--) send_bit(cfg[i], $urandom_range(0, 2), n);
        repeat (2) @(negedge clk);

        // Abort after 7 bits, concurrent with a valid bit
        for (int i = 0; i < 7; i++) send_bit(1'($urandom), 0, n);
        bif.cfg_abort    = 1'b1;
        bif.cfg_in_valid = 1'b1;
        bif.cfg_in_data  = 1'b1;
        chk("abort_ready", bif.cfg_in_ready, 1);
        @(posedge clk);
        m_cnt = 0;
        @(negedge clk);
        bif.cfg_abort    = 1'b0;
        bif.cfg_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        load(12'b01_1100_10_0001, 1);
        repeat (2) @(negedge clk);

        // Chain: cfg_out replays the stream CB shifts late
        chain_q.delete();
        for (int k = 1; k <= 2 * CB; k++) begin
            send_bit(1'($urandom), 0, n);
            if (k >= CB) chk("chain_out", bif.cfg_out, chain_q.pop_front());
        end
        repeat (2) @(negedge clk);

        // Reset in the middle of a load
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0, n);
        rst = 1'b1;
        #1;
        chk("midrst_ch_t", bif.ch_t, 2'b11);
        chk("midrst_active", bif.cfg_active, 0);
        chk("midrst_ready", bif.cfg_in_ready, 1);
        chk("midrst_cfg_out", bif.cfg_out, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Out-of-range I-select on the 12-wire instance: ch0 T=3 I=13, ch1 T=0 I=2
        load(12'b00_0010_11_1101, 0);
        @(negedge clk);
        bif.wires_in = 16'hFFFF;
        @(negedge clk);
        #1;
        chk("i12_oob_sel", bif12.ch_i[0], 0);
        chk("i16_sel13", bif.ch_i[0], 1);
        chk("t12_src_b", bif12.ch_t[0], 1);
        @(negedge clk);
        bif.wires_in = 16'hDFFF;
        @(negedge clk);
        #1;
        chk("i16_sel13_low", bif.ch_i[0], 0);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
